// File: rtl/scan_chain_sequencer.sv
// Purpose : Wishbone-controlled scan chain sequencer; shifts a CHAIN_LEN-bit image into the core while capturing the old chain.
// Latency : WB ack one cycle after accept; scan_enable high for CHAIN_LEN cycles after the GO ack edge, DONE one cycle later.
// Backpr. : single outstanding WB access; ack is high for one cycle, so a held strobe gets one idle cycle between accesses.
//
// Ports:
//   wb_clk_i / wb_rst_i        clock, synchronous active-high reset
//   wbs_*                      Wishbone slave: cyc/stb/we/sel/adr/dat in, ack/dat out
//   scan_enable/scan_in        shift enable and serial data towards the core
//   scan_out                   serial data returning from the core chain tail
//   halt                       core halt flag, reported in STAT only
//   proc_en                    core run enable, forced low while a scan is in flight
//   irq_o                      level interrupt, DONE && IRQ_EN
module scan_chain_sequencer #(
    parameter int CHAIN_LEN = 96
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        scan_enable,
    output logic        scan_in,
    input  logic        scan_out,
    input  logic        halt,
    output logic        proc_en,
    output logic        irq_o
);

    localparam int WORDS = (CHAIN_LEN + 31) / 32;
    localparam int PW    = WORDS * 32;
    localparam int CW    = $clog2(CHAIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    state_t               r_state;
    logic [CHAIN_LEN-1:0] r_img;
    logic [CW-1:0]        r_cnt;
    logic                 r_proc_go;
    logic                 r_irq_en;
    logic                 r_done;
    logic                 r_err;
    logic                 r_ack;
    logic                 r_scan_en;

    logic        w_acc;
    logic        w_wr;
    logic [7:0]  w_adr;
    logic [7:0]  w_off;
    logic [5:0]  w_word;
    logic        w_is_ctrl;
    logic        w_is_stat;
    logic        w_is_data;
    logic        w_busy;
    logic        w_go_req;
    logic        w_go_ok;
    logic        w_err_set;
    logic        w_clr_done;
    logic        w_clr_err;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic [PW-1:0] w_pad;
    logic [PW-1:0] w_pad_wr;
    logic [31:0] w_rdat;
    logic        w_unused_adr;

    // Only the low address byte is decoded.
    assign w_unused_adr = ^wbs_adr_i[31:8];

    always_comb begin
        w_adr     = wbs_adr_i[7:0];
        w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack;
        w_wr      = w_acc & wbs_we_i;
        w_is_ctrl = (w_adr == 8'h00);
        w_is_stat = (w_adr == 8'h04);
        w_off     = w_adr - 8'h10;
        w_word    = w_off[7:2];
        w_is_data = (w_adr >= 8'h10) && (w_off[1:0] == 2'b00) && (int'(w_word) < WORDS);
        w_busy    = (r_state != S_IDLE);

        // Image zero-padded to whole words: bits above CHAIN_LEN read 0 and
        // are dropped again when the written word is truncated back.
        w_pad = '0;
        w_pad[CHAIN_LEN-1:0] = r_img;
        w_pad_wr = w_pad;
        if (w_is_data) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs_sel_i[b]) begin
                    w_pad_wr[int'(w_word)*32 + b*8 +: 8] = wbs_dat_i[b*8 +: 8];
                end
            end
        end

        // GO lives in lane 0; the PROC_GO bit of the same write decides
        // whether the scan is allowed (a running core must not be scanned).
        w_go_req  = w_wr & w_is_ctrl & wbs_sel_i[0] & wbs_dat_i[0];
        w_go_ok   = w_go_req & ~w_busy & ~wbs_dat_i[1];
        w_err_set = (w_go_req & (w_busy | wbs_dat_i[1])) | (w_wr & w_is_data & w_busy);

        w_clr_done = w_wr & w_is_stat & wbs_sel_i[0] & wbs_dat_i[1];
        w_clr_err  = w_wr & w_is_stat & wbs_sel_i[0] & wbs_dat_i[2];
        // Set has priority over a same-edge W1C.
        w_done_nxt = (r_state == S_FIN) | (r_done & ~w_clr_done);
        w_err_nxt  = w_err_set | (r_err & ~w_clr_err);

        w_rdat = 32'h0;
        if (w_is_ctrl) begin
            w_rdat = {29'h0, r_irq_en, r_proc_go, 1'b0};
        end else if (w_is_stat) begin
            w_rdat = {27'h0, proc_en, halt, r_err, r_done, w_busy};
        end else if (w_is_data) begin
            w_rdat = w_pad[int'(w_word)*32 +: 32];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_img     <= '0;
            r_cnt     <= '0;
            r_proc_go <= 1'b0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ack     <= 1'b0;
            r_scan_en <= 1'b0;
        end else begin
            r_ack  <= w_acc;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;

            // PROC_GO/IRQ_EN are stored even while busy; proc_en is gated by state.
            if (w_wr && w_is_ctrl && wbs_sel_i[0]) begin
                r_proc_go <= wbs_dat_i[1];
                r_irq_en  <= wbs_dat_i[2];
            end

            case (r_state)
                S_IDLE: begin
                    r_scan_en <= 1'b0;
                    if (w_go_ok) begin
                        r_state   <= S_SHIFT;
                        r_cnt     <= CW'(CHAIN_LEN - 1);
                        r_scan_en <= 1'b1;
                    end else if (w_wr && w_is_data) begin
                        r_img <= w_pad_wr[CHAIN_LEN-1:0];
                    end
                end
                S_SHIFT: begin
                    // MSB leaves on scan_in while the chain tail enters at the LSB,
                    // so after CHAIN_LEN shifts the image holds the old chain in order.
                    r_img <= {r_img[CHAIN_LEN-2:0], scan_out};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state   <= S_FIN;
                        r_scan_en <= 1'b0;
                    end
                end
                S_FIN: begin
                    r_state   <= S_IDLE;
                    r_scan_en <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_scan_en <= 1'b0;
                end
            endcase
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = w_rdat;
    assign scan_enable = r_scan_en;
    assign scan_in     = r_img[CHAIN_LEN-1];
    assign proc_en     = r_proc_go & (r_state == S_IDLE);
    assign irq_o       = r_done & r_irq_en;

endmodule
